// File: rtl/freq_pkg.sv
// Constants and state encoding shared by the FFT RAM writer and the frequency detector.
package freq_pkg;
  localparam int N_FFT  = 1024;
  localparam int ADDR_W = 10;
  localparam int OUT_W  = 14;
  localparam int RAM_W  = 2 * OUT_W;
  localparam int DROP_W = 8;

  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_WAIT_DET = 2'd2
  } writer_state_t;
endpackage

// File: rtl/fft_ram_writer_sat_shift.sv
// Arithmetic right shift (floor) followed by signed saturation from IN_W to OUT_W bits.
module sat_shift #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 14,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);
  localparam logic signed [IN_W-1:0] MAX_V = IN_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] MIN_V = IN_W'(-(1 << (OUT_W - 1)));

  logic signed [IN_W-1:0] shifted;
  assign shifted = din >>> SHIFT;

  always_comb begin
    if (shifted > MAX_V)
      dout = MAX_V[OUT_W-1:0];
    else if (shifted < MIN_V)
      dout = MIN_V[OUT_W-1:0];
    else
      dout = shifted[OUT_W-1:0];
  end
endmodule

// File: rtl/fft_ram_writer.sv
// Captures one streamed FFT frame into the result RAM, then locks until the detector
// reports detectdone. Malformed frames are aborted with a lenerr pulse.
module fft_ram_writer
  import freq_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int SHIFT = 0
) (
  input  logic                   clk,
  input  logic [3:0]             KEY,
  input  logic                   sink_valid,
  input  logic                   sink_sop,
  input  logic                   sink_eop,
  input  logic signed [IN_W-1:0] sink_real,
  input  logic signed [IN_W-1:0] sink_imag,
  output logic                   sink_ready,
  input  logic                   detectdone,
  output logic                   wren,
  output logic [ADDR_W-1:0]      wraddr,
  output logic [RAM_W-1:0]       wrdata,
  output logic                   fftdone,
  output logic                   lenerr,
  output logic [DROP_W-1:0]      dropcount
);
  logic reset_n;
  logic unused_key;
  assign reset_n    = KEY[0];
  assign unused_key = ^KEY[3:1];

  writer_state_t       state_reg, state_next;
  logic [ADDR_W-1:0]   cnt_reg, cnt_next;
  logic                fin_reg, fin_next;
  logic                wren_reg, wren_next;
  logic [ADDR_W-1:0]   wraddr_reg, wraddr_next;
  logic [RAM_W-1:0]    wrdata_reg, wrdata_next;
  logic                fftdone_reg;
  logic                lenerr_reg, lenerr_next;
  logic [DROP_W-1:0]   drop_reg, drop_next;

  logic signed [IN_W-1:0] comp_in [2];
  logic [OUT_W-1:0]       comp_out [2];
  logic [RAM_W-1:0]       scaled;
  logic                   accept;
  logic                   last_beat;

  assign comp_in[0] = sink_real;
  assign comp_in[1] = sink_imag;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sat
      sat_shift #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_sat (
        .din  (comp_in[gi]),
        .dout (comp_out[gi])
      );
    end
  endgenerate

  assign scaled     = {comp_out[0], comp_out[1]};
  assign sink_ready = (state_reg == ST_ARMED) || (state_reg == ST_CAPTURE);
  assign accept     = sink_valid & sink_ready;
  assign last_beat  = (cnt_reg == ADDR_W'(N_FFT - 1));

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    fin_next    = 1'b0;
    wren_next   = 1'b0;
    wraddr_next = wraddr_reg;
    wrdata_next = wrdata_reg;
    lenerr_next = 1'b0;
    drop_next   = drop_reg;
    case (state_reg)
      ST_ARMED: begin
        if (accept && sink_sop) begin
          if (sink_eop) begin
            lenerr_next = 1'b1;
          end else begin
            wren_next   = 1'b1;
            wraddr_next = '0;
            wrdata_next = scaled;
            cnt_next    = ADDR_W'(1);
            state_next  = ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: begin
        // The beat that exposes a framing error is dropped, not written.
        if (accept) begin
          if (sink_sop || (sink_eop != last_beat)) begin
            lenerr_next = 1'b1;
            cnt_next    = '0;
            state_next  = ST_ARMED;
          end else begin
            wren_next   = 1'b1;
            wraddr_next = cnt_reg;
            wrdata_next = scaled;
            if (last_beat) begin
              fin_next   = 1'b1;
              cnt_next   = '0;
              state_next = ST_WAIT_DET;
            end else begin
              cnt_next = cnt_reg + ADDR_W'(1);
            end
          end
        end
      end
      ST_WAIT_DET: begin
        if (sink_valid && sink_sop && (drop_reg != {DROP_W{1'b1}}))
          drop_next = drop_reg + DROP_W'(1);
        if (detectdone)
          state_next = ST_ARMED;
      end
      default: begin
        state_next = ST_ARMED;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= ST_ARMED;
      cnt_reg     <= '0;
      fin_reg     <= 1'b0;
      wren_reg    <= 1'b0;
      wraddr_reg  <= '0;
      wrdata_reg  <= '0;
      fftdone_reg <= 1'b0;
      lenerr_reg  <= 1'b0;
      drop_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      fin_reg     <= fin_next;
      wren_reg    <= wren_next;
      wraddr_reg  <= wraddr_next;
      wrdata_reg  <= wrdata_next;
      fftdone_reg <= fin_reg;
      lenerr_reg  <= lenerr_next;
      drop_reg    <= drop_next;
    end
  end

  assign wren      = wren_reg;
  assign wraddr    = wraddr_reg;
  assign wrdata    = wrdata_reg;
  assign fftdone   = fftdone_reg;
  assign lenerr    = lenerr_reg;
  assign dropcount = drop_reg;
endmodule
